serial_adder_ctrl: RTL and testbench

Bit-serial N-bit adder built around a single 1-bit full-adder cell.
- Latches two WIDTH-bit operands and a carry-in on a start request.
- Feeds the operand bits through the full adder LSB-first, one bit per clock, and carries the carry between cycles in a register.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Sits between a requester (test sequencer or top-level control) and the 1-bit adder datapath.

---
 rtl/serial_adder_ctrl_pkg.sv | 16 +
 rtl/serial_adder_ctrl_if.sv | 25 ++
 rtl/full_adder_1bit.sv | 13 +
 rtl/serial_adder_ctrl.sv | 80 ++++++++
 tb/tb_serial_adder_ctrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and its width.
package serial_adder_ctrl_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  typedef enum logic [ST_W-1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Requester-side handshake and result bus of the bit-serial adder.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder_1bit.sv
// Single-bit combinational full adder; the only arithmetic cell of the serial adder.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands are latched on start and summed LSB-first,
// one bit per clock, through a single full-adder cell.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic fa_s;
  logic fa_cout;

  full_adder_1bit u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            state_q <= StRun;
          end
        end
        StRun: begin
          // Result bits enter at the MSB so the sum is LSB-aligned after WIDTH shifts.
          sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            cout_q  <= fa_cout;
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomised self-checking bench for serial_adder_ctrl against an arithmetic reference.
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NRand = 200;

  logic clk;
  logic rst;

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  always @(negedge clk) if (bus_if.done === 1'b1) done_seen++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {cout,sum} is the plain (WIDTH+1)-bit sum of the operands.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  // Wait from the current negedge until done is seen, within a bounded number of cycles.
  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (bus_if.done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (bus_if.done !== 1'b1) check_eq("done_timeout", 64'(cycles), 64'(budget + 1));
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin);
    logic [WIDTH:0] exp;
    int cyc;
    exp = ref_add(a, b, cin);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.cin   = cin;
    @(negedge clk);
    check_eq({tag, "_busy"}, 64'(bus_if.busy), 64'd1);
    bus_if.start = 1'b0;
    // Operands are latched; scrambling them must not disturb the result.
    bus_if.a     = WIDTH'($urandom);
    bus_if.b     = WIDTH'($urandom);
    bus_if.cin   = 1'($urandom);
    wait_done(3 * WIDTH, cyc);
    check_eq({tag, "_latency"}, 64'(cyc), 64'(WIDTH));
    check_eq({tag, "_sum"}, 64'(bus_if.sum), 64'(exp[WIDTH-1:0]));
    check_eq({tag, "_cout"}, 64'(bus_if.cout), 64'(exp[WIDTH]));
    @(negedge clk);
    check_eq({tag, "_idle"}, 64'({bus_if.busy, bus_if.done}), 64'd0);
    check_eq({tag, "_held"}, 64'({bus_if.cout, bus_if.sum}), 64'(exp));
  endtask

  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] exp;
  int             cyc;
  int             snap;
  realtime        last_t;

  initial begin
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    bus_if.cin   = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(bus_if.busy), 64'd0);
    check_eq("rst_done", 64'(bus_if.done), 64'd0);
    check_eq("rst_sum", 64'(bus_if.sum), 64'd0);
    check_eq("rst_cout", 64'(bus_if.cout), 64'd0);
    rst = 1'b0;

    run_op("basic", 8'h5A, 8'h3C, 1'b0);
    run_op("ripple", 8'hFF, 8'h01, 1'b0);
    run_op("cin_ff", 8'hFF, 8'h00, 1'b1);
    run_op("cin_00", 8'h00, 8'h00, 1'b1);

    // Start pulsed while busy must be ignored, not queued.
    snap = done_seen;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a = 8'h10; bus_if.b = 8'h20; bus_if.cin = 1'b0;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a = 8'hFF; bus_if.b = 8'hFF;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_done(3 * WIDTH, cyc);
    check_eq("busy_ign_sum", 64'(bus_if.sum), 64'h30);
    check_eq("busy_ign_cout", 64'(bus_if.cout), 64'd0);
    repeat (2 * WIDTH) @(negedge clk);
    check_eq("busy_ign_pulses", 64'(done_seen - snap), 64'd1);
    check_eq("busy_ign_idle", 64'(bus_if.busy), 64'd0);

    // Reset in the middle of an operation aborts it with no done pulse.
    snap = done_seen;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a = 8'hAA; bus_if.b = 8'h55; bus_if.cin = 1'b0;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_outs", 64'({bus_if.busy, bus_if.done, bus_if.cout, bus_if.sum}), 64'd0);
    repeat (2 * WIDTH) @(negedge clk);
    check_eq("midrst_pulses", 64'(done_seen - snap), 64'd0);
    run_op("after_rst", 8'h01, 8'h01, 1'b0);

    // Back-to-back: start held high, operands updated only when a result is presented.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a   = WIDTH'($urandom);
    bus_if.b   = WIDTH'($urandom);
    bus_if.cin = 1'($urandom);
    exp_q.push_back(ref_add(bus_if.a, bus_if.b, bus_if.cin));
    last_t = 0;
    for (int i = 0; i < NRand; i++) begin
      wait_done(3 * WIDTH, cyc);
      if (bus_if.done !== 1'b1) break;
      exp = exp_q.pop_front();
      check_eq("rand_result", 64'({bus_if.cout, bus_if.sum}), 64'(exp));
      if (i > 0) check_eq("rand_spacing", 64'(int'(($realtime - last_t) / 10.0)), 64'(WIDTH + 2));
      last_t = $realtime;
      bus_if.a   = WIDTH'($urandom);
      bus_if.b   = WIDTH'($urandom);
      bus_if.cin = 1'($urandom);
      exp_q.push_back(ref_add(bus_if.a, bus_if.b, bus_if.cin));
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    repeat (2 * WIDTH) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
